// File: rtl/ps2_keyboard_wb.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_wb
// Purpose  : Wishbone slave that receives PS/2 keyboard frames and queues the
//            scan-code bytes for the CPU.
// Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_wb #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    input  logic        ps2_clk,
    input  logic        ps2_data
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tmax = c_tw'(TIMEOUT);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [1:0]      r_clk_sync, r_dat_sync;
    logic [3:0]      r_filt;
    logic            r_clk_f, r_fall;
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [c_tw-1:0] r_tcnt;
    logic            w_timeout, w_push, w_ferr_set;
    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr, r_rd;
    logic [c_aw:0]   r_count;
    logic            r_ovf, r_ferr;
    logic            w_xfer, w_valid, w_full, w_pop, w_wr_en;
    logic [7:0]      w_head;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_unused = ^{DAT_I[31:11], DAT_I[8:0]};

    // Filtered clock only moves once four synced samples agree; the fall
    // pulse is registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt     <= 4'hF;
            r_clk_f    <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_filt     <= {r_filt[2:0], r_clk_sync[1]};
            r_fall     <= 1'b0;
            if (r_filt == 4'hF) begin
                r_clk_f <= 1'b1;
            end else if (r_filt == 4'h0) begin
                r_clk_f <= 1'b0;
                r_fall  <= r_clk_f;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        w_timeout   = (r_state != ST_IDLE) && !r_fall && (r_tcnt == c_tmax);
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_ferr_set  = 1'b1;
        end else if (r_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_sync[1]) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (r_dat_sync[1] && (^{r_shift, r_par})) w_push = 1'b1;
                    else                                       w_ferr_set = 1'b1;
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            if (r_fall || r_state == ST_IDLE) r_tcnt <= '0;
            else if (r_tcnt != c_tmax)        r_tcnt <= r_tcnt + 1'b1;
            if (r_fall) begin
                case (r_state)
                    ST_IDLE:   r_bitcnt <= '0;
                    ST_DATA: begin
                        r_shift  <= {r_dat_sync[1], r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    ST_PARITY: r_par <= r_dat_sync[1];
                    default:   ;
                endcase
            end
        end
    end

    assign w_xfer   = STB & ~ACK;
    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == c_full);
    assign w_pop    = w_xfer & ~WE & w_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en  = w_push & (~w_full | w_pop);
    assign w_head   = w_valid ? r_mem[r_rd] : 8'h00;
    assign w_status = {8'h00, 8'(r_count), 5'b00000, r_ferr, r_ovf, w_valid, w_head};

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= r_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ACK     <= 1'b0;
            DAT_O   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            ACK <= w_xfer;
            if (w_xfer) DAT_O <= WE ? {w_status[31:8], 8'h00} : w_status;
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_wr_en) r_count <= r_count - 1'b1;
            r_ovf  <= (w_push & w_full & ~w_pop) | (r_ovf & ~(w_xfer & WE & DAT_I[9]));
            r_ferr <= w_ferr_set | (r_ferr & ~(w_xfer & WE & DAT_I[10]));
        end
    end
endmodule
`default_nettype wire

// File: doc/ps2_keyboard_wb.md
# ps2_keyboard_wb

Wishbone slave that receives PS/2 keyboard scan-code bytes and queues them for the CPU. It sits on intercon slave port 3, where it drives `Keyboard_ACK`/`Keyboard_DAT_O`, and responds to CPU strobes. Internally it has a synchronizer/filter on the PS/2 lines, a frame-receive FSM and a byte FIFO. CPU reads pop the FIFO; CPU writes clear the sticky error flags.

## Interface
- `DEPTH`, 16: FIFO entries, 8 bits each. Power of two, 2..128.
- `TIMEOUT`, 50000: clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `STB` input 1: Wishbone strobe from the intercon.
- `WE` input 1: 1 = write, 0 = read. Sampled with `STB`.
- `DAT_I` input 32: write data.
- `DAT_O` output 32: registered read/status data.
- `ACK` output 1: registered single-cycle acknowledge.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data, asynchronous to `clk`.

## Operation
- **Input conditioning**
  - Both PS/2 lines pass through a 2-FF synchronizer.
  - `ps2_clk` then goes through a 4-sample filter. The filtered clock changes only when 4 consecutive synced samples agree; its reset value is 1.
  - A falling edge of the filtered clock produces a 1-cycle `fall` pulse. Data is sampled from the synced `ps2_data` on `fall`.
- **Frame FSM.** States are IDLE, DATA, PARITY, STOP. Every transition below happens on `fall`.
  - IDLE: data=0 -> DATA with bitcnt=0. data=1 -> stay in IDLE.
  - DATA: shift the data bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: the frame is valid if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Valid frame: push the byte.
    - Invalid frame: set `frame_err` and discard the byte.
    - Either way -> IDLE.
  - Timeout: in any state other than IDLE, `TIMEOUT` cycles without a `fall` -> abort to IDLE. Discard the byte and set `frame_err`.
- **FIFO**
  - Circular buffer with `DEPTH` entries, plus a count of 0..DEPTH.
  - Push when full: drop the byte and set `overflow`.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full, and does not set `overflow`.
- **Status word.** Any field not listed is 0.
  - `[7:0]` head byte, or 0 if the FIFO is empty.
  - `[8]` valid (FIFO non-empty).
  - `[9]` overflow.
  - `[10]` frame_err.
  - `[23:16]` count, zero-extended.
- **Read** (`STB`=1, `WE`=0)
  - `DAT_O` is loaded with the status word as it was before the pop.
  - If valid, the FIFO pops in the same cycle that `ACK` rises.
  - A read of an empty FIFO returns valid=0 and pops nothing.
- **Write** (`STB`=1, `WE`=1)
  - `DAT_I[9]`=1 clears `overflow`; `DAT_I[10]`=1 clears `frame_err`.
  - A write never pops.
  - `DAT_O` is loaded with the status word, with `[7:0]` forced to 0.
  - A flag clear and a flag set in the same cycle: the set wins.

## Timing
- **Reset.** On `reset`=0:
  - `ACK`=0 and `DAT_O`=0.
  - FIFO empty, both flags 0.
  - FSM in IDLE, filter and synchronizer stages at 1, timeout counter at 0.
  - Reset during a frame discards the partial byte.
- **Handshake**
  - `ACK` is registered as `STB & ~ACK`. It rises the cycle after `STB` is sampled high and lasts exactly 1 cycle.
  - The master holds `STB` until it sees `ACK`. `DAT_O` is valid in the `ACK` cycle and holds until the next `ACK`.
  - If `STB` stays high after `ACK`, `ACK` repeats every other cycle. Exactly one transaction, and one pop, occurs per `ACK`.
- **Receive latency**
  - Raw `ps2_clk` fall -> `fall` pulse takes 2 (sync) + 4 (filter) + 1 cycles.
  - The byte is visible in the status word the cycle after the stop-bit `fall`.
- **Timeout counter.** Resets on every `fall` and on entry to IDLE, and saturates at `TIMEOUT`.

## Test plan
- **Single frame.** Send 0x1C as 0, 00111000 (LSB-first), parity 0, stop 1, with a 40 µs bit period. A read then returns `DAT_O`=0x0001011C, meaning count 1, valid, data 0x1C. The next read returns 0x00000000.
- **Bad frame.** Send 0x1C with parity 1. No push occurs; a read returns 0x00000400. A write of 0x400 clears the flag, and the following read returns 0.
- **Timeout.** Send the start bit and 3 data bits, then hold `ps2_clk` high for `TIMEOUT`+10 cycles. `frame_err`=1 and the FIFO stays empty. The next full frame of 0xF0 is then received correctly.
- **Overflow.** Send `DEPTH`+1 frames (0x01..0x11) with no reads. The status reads count=16 with `[9]`=1, and `DEPTH` reads return 0x01..0x10 in order.
- **Simultaneous push/pop.** With the FIFO full, time a read `ACK` to land in the same cycle as the stop-bit push. Count stays 16, `overflow` stays 0, and the new byte appears last.
- **Reset mid-frame.** Assert `reset`=0 for 1 cycle after 4 data bits. `ACK`, `DAT_O` and the flags are all 0, and the next complete frame is received correctly.
